// File: rtl/solar_pkg.sv
// solar_pkg: shared axis state encoding, default parameters and threshold compare
package solar_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MOVE_P = 3'd1,
        MOVE_N = 3'd2,
        SETTLE = 3'd3,
        FAULT  = 3'd4
    } axis_state_t;

    localparam int DEF_W          = 8;
    localparam int DEF_TH_START   = 10;
    localparam int DEF_TH_STOP    = 2;
    localparam int DEF_TIMEOUT    = 1000;
    localparam int DEF_SETTLE_CYC = 16;

    // One extra bit on both sides so b + th can never wrap
    function automatic logic gt_th(input logic [31:0] a, input logic [31:0] b, input logic [31:0] th);
        return {1'b0, a} > ({1'b0, b} + {1'b0, th});
    endfunction

endpackage

// File: rtl/tracker_axis.sv
// tracker_axis: one balancing axis with hysteresis, settle dwell and move timeout fault
module tracker_axis
    import solar_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int TH_START   = DEF_TH_START,
    parameter int TH_STOP    = DEF_TH_STOP,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_p,
    input  logic [W-1:0] i_n,
    input  logic         i_enable,
    input  logic         i_fault_clr,
    output logic         o_mp,
    output logic         o_mn,
    output logic         o_fault,
    output logic         o_busy
);

    localparam int CNT_MAX = (TIMEOUT > SETTLE_CYC) ? TIMEOUT : SETTLE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    if (!(TH_STOP < TH_START && TIMEOUT >= 2 && SETTLE_CYC >= 1)) begin : g_param_check
        $error("tracker_axis: illegal parameters TH_STOP=%0d TH_START=%0d TIMEOUT=%0d SETTLE_CYC=%0d",
               TH_STOP, TH_START, TIMEOUT, SETTLE_CYC);
    end

    axis_state_t   r_state;
    axis_state_t   w_next;
    logic [CW-1:0] r_cnt;
    logic          w_go_p;
    logic          w_go_n;
    logic          w_keep_p;
    logic          w_keep_n;
    logic          w_timeout;
    logic          w_settled;

    assign w_go_p    = i_enable && gt_th(32'(i_p), 32'(i_n), 32'(TH_START));
    assign w_go_n    = i_enable && gt_th(32'(i_n), 32'(i_p), 32'(TH_START));
    assign w_keep_p  = i_enable && gt_th(32'(i_p), 32'(i_n), 32'(TH_STOP));
    assign w_keep_n  = i_enable && gt_th(32'(i_n), 32'(i_p), 32'(TH_STOP));
    assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
    assign w_settled = r_cnt == CW'(SETTLE_CYC - 1);

    // Next state: a stop request outranks the timeout so a coincident pair settles cleanly
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go_p ? MOVE_P : (w_go_n ? MOVE_N : IDLE);
            MOVE_P:  w_next = !w_keep_p ? SETTLE : (w_timeout ? FAULT : MOVE_P);
            MOVE_N:  w_next = !w_keep_n ? SETTLE : (w_timeout ? FAULT : MOVE_N);
            SETTLE:  w_next = w_settled ? IDLE : SETTLE;
            FAULT:   w_next = i_fault_clr ? IDLE : FAULT;
            default: w_next = IDLE;
        endcase
    end

    // State, dwell/timeout counter and outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            o_mp    <= 1'b0;
            o_mn    <= 1'b0;
            o_fault <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == IDLE || r_state == FAULT) ? '0 : r_cnt + 1'b1;
            o_mp    <= w_next == MOVE_P;
            o_mn    <= w_next == MOVE_N;
            o_fault <= w_next == FAULT;
            o_busy  <= w_next == MOVE_P || w_next == MOVE_N || w_next == SETTLE;
        end
    end

endmodule

// File: rtl/solar_tracker_2axis.sv
// solar_tracker_2axis: two independent sun-tracking axes driving N/S and E/W motor enables
module solar_tracker_2axis
    import solar_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int TH_START   = DEF_TH_START,
    parameter int TH_STOP    = DEF_TH_STOP,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] lsn,
    input  logic [W-1:0] lse,
    input  logic [W-1:0] lss,
    input  logic [W-1:0] lsw,
    input  logic         enable,
    input  logic         fault_clr,
    output logic         mn,
    output logic         ms,
    output logic         me,
    output logic         mw,
    output logic         fault_ns,
    output logic         fault_ew,
    output logic         busy
);

    logic w_busy_ns;
    logic w_busy_ew;

    tracker_axis #(
        .W(W), .TH_START(TH_START), .TH_STOP(TH_STOP), .TIMEOUT(TIMEOUT), .SETTLE_CYC(SETTLE_CYC)
    ) u_ns (
        .clk(clk), .rst(rst), .i_p(lsn), .i_n(lss), .i_enable(enable), .i_fault_clr(fault_clr),
        .o_mp(mn), .o_mn(ms), .o_fault(fault_ns), .o_busy(w_busy_ns)
    );

    tracker_axis #(
        .W(W), .TH_START(TH_START), .TH_STOP(TH_STOP), .TIMEOUT(TIMEOUT), .SETTLE_CYC(SETTLE_CYC)
    ) u_ew (
        .clk(clk), .rst(rst), .i_p(lse), .i_n(lsw), .i_enable(enable), .i_fault_clr(fault_clr),
        .o_mp(me), .o_mn(mw), .o_fault(fault_ew), .o_busy(w_busy_ew)
    );

    assign busy = w_busy_ns | w_busy_ew;

endmodule

// File: tb/tb_solar_tracker_2axis.sv
// tb_solar_tracker_2axis: directed plus random stimulus against a cycle-level behavioural model
module tb_solar_tracker_2axis;

    localparam int W  = 8;
    localparam int TS = 10;
    localparam int TP = 2;
    localparam int TO = 1000;
    localparam int SC = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         fault_clr = 1'b0;
    logic [W-1:0] lsn = '0, lse = '0, lss = '0, lsw = '0;
    logic         mn, ms, me, mw, fault_ns, fault_ew, busy;

    int total = 0;
    int bad   = 0;

    // Model per axis: motor direction (+1/-1/0), cycles the motor has been on,
    // remaining settle cycles, latched fault
    int dir[2];
    int on_t[2];
    int stl[2];
    bit flt[2];

    solar_tracker_2axis dut (
        .clk(clk), .rst(rst), .lsn(lsn), .lse(lse), .lss(lss), .lsw(lsw),
        .enable(enable), .fault_clr(fault_clr),
        .mn(mn), .ms(ms), .me(me), .mw(mw),
        .fault_ns(fault_ns), .fault_ew(fault_ew), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        for (int a = 0; a < 2; a++) begin
            dir[a]  = 0;
            on_t[a] = 0;
            stl[a]  = 0;
            flt[a]  = 1'b0;
        end
    endfunction

    function automatic void m_step();
        int diff[2];
        diff[0] = int'(lsn) - int'(lss);
        diff[1] = int'(lse) - int'(lsw);
        for (int a = 0; a < 2; a++) begin
            if (flt[a]) begin
                if (fault_clr) flt[a] = 1'b0;
            end else if (dir[a] != 0) begin
                if (!enable || dir[a] * diff[a] <= TP) begin
                    dir[a] = 0;
                    stl[a] = SC;
                end else if (on_t[a] == TO) begin
                    dir[a] = 0;
                    flt[a] = 1'b1;
                end else begin
                    on_t[a]++;
                end
            end else if (stl[a] > 0) begin
                stl[a]--;
            end else if (enable && diff[a] > TS) begin
                dir[a]  = 1;
                on_t[a] = 1;
            end else if (enable && -diff[a] > TS) begin
                dir[a]  = -1;
                on_t[a] = 1;
            end
        end
    endfunction

    function automatic logic [6:0] m_exp();
        return {dir[0] == 1, dir[0] == -1, dir[1] == 1, dir[1] == -1, flt[0], flt[1],
                (dir[0] != 0 || stl[0] > 0 || dir[1] != 0 || stl[1] > 0)};
    endfunction

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (mn ms me mw fns few busy)", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        if (rst) m_reset();
        else m_step();
        @(negedge clk);
        chk(tag, {mn, ms, me, mw, fault_ns, fault_ew, busy}, m_exp());
    endtask

    task automatic run(input int k, input string tag);
        repeat (k) cyc(tag);
    endtask

    function automatic logic [W-1:0] clip(input int v);
        return (v < 0) ? '0 : (v > 255) ? 8'd255 : W'(v);
    endfunction

    initial begin
        int b;
        m_reset();
        lsn = 100; lse = 100; lss = 100; lsw = 100;
        enable = 1'b1;
        #1;
        chk("reset_async", {mn, ms, me, mw, fault_ns, fault_ew, busy}, 7'b0);
        run(3, "reset_hold");
        rst = 1'b0;
        run(50, "idle");
        // Hysteresis on N/S
        lsn = 120;
        cyc("start_ns");
        chk("start_mn_literal", {6'b0, mn}, 7'd1);
        lsn = 111;
        run(5, "hyst_hold");
        lsn = 103;
        run(3, "stop_edge_plus1");
        lsn = 102;
        run(20, "stop_settle");
        // Start threshold boundary and no-wrap compare on E/W
        lse = 210; lsw = 200;
        run(5, "eq_th_start");
        lse = 211;
        run(3, "above_th_start");
        lse = 200;
        run(20, "ew_stop");
        lse = 255; lsw = 250;
        run(5, "no_wrap");
        // Timeout and fault clear on W
        lse = 0; lsw = 200;
        run(1005, "timeout");
        chk("fault_ew_literal", {6'b0, fault_ew}, 7'd1);
        run(5, "fault_hold");
        fault_clr = 1'b1;
        cyc("fault_clr");
        fault_clr = 1'b0;
        run(3, "restart_after_clr");
        lse = 100; lsw = 100;
        run(20, "ew_stop2");
        // Concurrency and enable
        lsn = 200; lss = 0; lse = 200; lsw = 0;
        run(5, "both_move");
        enable = 1'b0;
        run(30, "disabled");
        enable = 1'b1;
        run(5, "reenabled");
        lsn = 100; lss = 100; lse = 100; lsw = 100;
        run(25, "quiet");
        // Async reset mid-move on S
        lsn = 0; lss = 200;
        run(3, "ms_move");
        #2 rst = 1'b1;
        #1;
        m_reset();
        chk("async_kill", {mn, ms, me, mw, fault_ns, fault_ew, busy}, 7'b0);
        run(2, "rst_mid");
        rst = 1'b0;
        run(5, "restart_after_rst");
        lsn = 100; lss = 100;
        run(25, "quiet2");
        // Random traffic with occasional long holds to reach timeouts
        repeat (300) begin
            b = int'($urandom_range(0, 255));
            lsn = W'(b);
            lss = clip(b + int'($urandom_range(0, 40)) - 20);
            b = int'($urandom_range(0, 255));
            lse = W'(b);
            lsw = clip(b + int'($urandom_range(0, 40)) - 20);
            enable = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 5) == 0) begin
                fault_clr = 1'b1;
                cyc("rand_clr");
                fault_clr = 1'b0;
            end
            run(($urandom_range(0, 29) == 0) ? 1050 : int'($urandom_range(1, 40)), "random");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
